// File: rtl/gpio_debounce_if.sv
// ============================================================================
//  Module      : gpio_debounce_if
//  Description : Wishbone classic slave bundle for the gpio_debounce block.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface gpio_debounce_if;
    logic [7:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic       wb_we_i;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic [2:0] wb_cti_i;
    logic [1:0] wb_bte_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic       wb_err_o;
    logic       wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

`default_nettype wire

// File: rtl/gpio_debounce.sv
// ============================================================================
//  Module      : gpio_debounce
//  Description : 8-bit pad synchroniser, tick-based debouncer, edge detector
//                and level interrupt with a small Wishbone register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gpio_debounce #(
    parameter int PRESCALE       = 100,
    parameter int DEFAULT_THRESH = 4
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    gpio_debounce_if.slave        wb,
    input  logic [7:0]            pad_i,
    output logic [7:0]            gpio_db_o,
    output logic                  irq_o
);

    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);
    localparam logic [7:0]  THRESH_RST   = 8'(DEFAULT_THRESH);

    localparam logic [7:0]  ADR_LEVEL    = 8'd0;
    localparam logic [7:0]  ADR_RISE_EN  = 8'd1;
    localparam logic [7:0]  ADR_FALL_EN  = 8'd2;
    localparam logic [7:0]  ADR_PENDING  = 8'd3;
    localparam logic [7:0]  ADR_THRESH   = 8'd4;

    logic [7:0]  sync_meta;
    logic [7:0]  sync;
    logic [15:0] presc_cnt;
    logic        tick;
    logic [7:0]  db;
    logic [7:0]  db_q;
    logic [7:0]  edge_evt;
    logic [7:0]  pending;
    logic [7:0]  rise_en;
    logic [7:0]  fall_en;
    logic [7:0]  thresh;
    logic        ack;
    logic [7:0]  dat_out;
    logic [7:0]  rd_data;

    logic        bus_req;
    logic        bus_wr;
    logic        wr_rise_en;
    logic        wr_fall_en;
    logic        wr_pending;
    logic        wr_thresh;
    logic [7:0]  w1c_mask;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        unused_bus_bits;

    assign unused_bus_bits = ^{wb.wb_cti_i, wb.wb_bte_i};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign bus_req    = wb.wb_cyc_i & wb.wb_stb_i;
    assign bus_wr     = bus_req & wb.wb_we_i;
    assign wr_rise_en = bus_wr & (wb.wb_adr_i == ADR_RISE_EN);
    assign wr_fall_en = bus_wr & (wb.wb_adr_i == ADR_FALL_EN);
    assign wr_pending = bus_wr & (wb.wb_adr_i == ADR_PENDING);
    assign wr_thresh  = bus_wr & (wb.wb_adr_i == ADR_THRESH);
    assign w1c_mask   = wr_pending ? wb.wb_dat_i : 8'h00;

    // ------------------------------------------------------------------
    // Pad synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_meta <= 8'h00;
            sync      <= 8'h00;
        end else begin
            sync_meta <= pad_i;
            sync      <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce tick prescaler
    // ------------------------------------------------------------------
    assign tick = (presc_cnt == PRESCALE_MAX);

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            presc_cnt <= 16'd0;
        end else if (tick) begin
            presc_cnt <= 16'd0;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce filter
    // ------------------------------------------------------------------
    for (genvar b = 0; b < 8; b++) begin : g_bit
        logic [7:0] cnt;
        logic [8:0] cnt_inc;
        logic       db_bit;

        assign cnt_inc = {1'b0, cnt} + 9'd1;
        assign db[b]   = db_bit;

        // A threshold write only restarts filtering; the level is kept.
        always_ff @(posedge wb_clk or negedge wb_rst_n) begin
            if (!wb_rst_n) begin
                cnt    <= 8'd0;
                db_bit <= 1'b0;
            end else if (wr_thresh) begin
                cnt    <= 8'd0;
            end else if (thresh == 8'd0) begin
                cnt    <= 8'd0;
                db_bit <= sync[b];
            end else if (sync[b] == db_bit) begin
                cnt    <= 8'd0;
            end else if (tick) begin
                if (cnt_inc == {1'b0, thresh}) begin
                    db_bit <= sync[b];
                    cnt    <= 8'd0;
                end else if (cnt != 8'hFF) begin
                    cnt    <= cnt_inc[7:0];
                end
            end
        end
    end

    assign gpio_db_o = db;

    // ------------------------------------------------------------------
    // Edge detection and pending flags
    // ------------------------------------------------------------------
    assign rise = db & ~db_q & rise_en;
    assign fall = ~db & db_q & fall_en;

    // Edge events are registered once before landing in pending, so a
    // debounced change shows up on irq two cycles later.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            db_q     <= 8'h00;
            edge_evt <= 8'h00;
            pending  <= 8'h00;
        end else begin
            db_q     <= db;
            edge_evt <= rise | fall;
            pending  <= (pending & ~w1c_mask) | edge_evt;
        end
    end

    assign irq_o = |pending;

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rise_en <= 8'h00;
            fall_en <= 8'h00;
            thresh  <= THRESH_RST;
        end else begin
            if (wr_rise_en) begin
                rise_en <= wb.wb_dat_i;
            end
            if (wr_fall_en) begin
                fall_en <= wb.wb_dat_i;
            end
            if (wr_thresh) begin
                thresh  <= wb.wb_dat_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path and acknowledge
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        case (wb.wb_adr_i)
            ADR_LEVEL:   rd_data = db;
            ADR_RISE_EN: rd_data = rise_en;
            ADR_FALL_EN: rd_data = fall_en;
            ADR_PENDING: rd_data = pending;
            ADR_THRESH:  rd_data = thresh;
            default:     rd_data = 8'h00;
        endcase
    end

    // Ack drops after every beat, so a held strobe is served every other cycle.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack     <= 1'b0;
            dat_out <= 8'h00;
        end else begin
            ack     <= bus_req & ~ack;
            dat_out <= rd_data;
        end
    end

    assign wb.wb_ack_o = ack;
    assign wb.wb_dat_o = dat_out;
    assign wb.wb_err_o = 1'b0;
    assign wb.wb_rty_o = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_gpio_debounce.sv
// ============================================================================
//  Module      : tb_gpio_debounce
//  Description : Randomised scoreboard bench for gpio_debounce.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gpio_debounce;

    localparam int PRESCALE = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pad   = 8'h00;
    logic [7:0] gpio_db;
    logic       irq;

    int errors = 0;
    int checks = 0;

    gpio_debounce_if bus ();

    gpio_debounce #(
        .PRESCALE       (PRESCALE),
        .DEFAULT_THRESH (4)
    ) dut (
        .wb_clk    (clk),
        .wb_rst_n  (rst_n),
        .wb        (bus),
        .pad_i     (pad),
        .gpio_db_o (gpio_db),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    // Reference model state, stepped once per clock from the spec rules.
    typedef struct packed {
        logic [7:0]       s1;
        logic [7:0]       s2;
        logic [7:0]       db;
        logic [7:0]       dbq;
        logic [7:0]       evt;
        logic [7:0]       pend;
        logic [7:0]       ren;
        logic [7:0]       fen;
        logic [7:0]       thr;
        logic [7:0][7:0]  ticks;
        logic [15:0]      pc;
        logic             ack;
    } model_t;

    model_t     m;
    logic [7:0] exp_q[$];

    function automatic model_t model_reset();
        model_t r;
        r     = '0;
        r.thr = 8'd4;
        return r;
    endfunction

    function automatic logic [7:0] reg_value(model_t s, logic [7:0] adr);
        case (adr)
            8'd0:    return s.db;
            8'd1:    return s.ren;
            8'd2:    return s.fen;
            8'd3:    return s.pend;
            8'd4:    return s.thr;
            default: return 8'h00;
        endcase
    endfunction

    function automatic model_t model_step(model_t s, logic [7:0] p, logic cyc, logic stb,
                                          logic we, logic [7:0] adr, logic [7:0] dat);
        model_t n;
        bit     tk;
        bit     wr;
        n  = s;
        tk = (int'(s.pc) == PRESCALE - 1);
        wr = cyc && stb && we;
        n.s1 = p;
        n.s2 = s.s1;
        n.pc = tk ? 16'd0 : s.pc + 16'd1;
        for (int b = 0; b < 8; b++) begin
            if (wr && adr == 8'd4) begin
                n.ticks[b] = 8'd0;
            end else if (s.thr == 8'd0) begin
                n.ticks[b] = 8'd0;
                n.db[b]    = s.s2[b];
            end else if (s.s2[b] == s.db[b]) begin
                n.ticks[b] = 8'd0;
            end else if (tk) begin
                if (int'(s.ticks[b]) + 1 >= int'(s.thr)) begin
                    n.db[b]    = s.s2[b];
                    n.ticks[b] = 8'd0;
                end else if (s.ticks[b] != 8'hFF) begin
                    n.ticks[b] = s.ticks[b] + 8'd1;
                end
            end
        end
        n.dbq  = s.db;
        n.evt  = (s.db & ~s.dbq & s.ren) | (~s.db & s.dbq & s.fen);
        n.pend = (s.pend & ~((wr && adr == 8'd3) ? dat : 8'h00)) | s.evt;
        if (wr && adr == 8'd1) n.ren = dat;
        if (wr && adr == 8'd2) n.fen = dat;
        if (wr && adr == 8'd4) n.thr = dat;
        n.ack = cyc && stb && !s.ack;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= model_reset();
            exp_q.delete();
        end else begin
            if (bus.wb_cyc_i && bus.wb_stb_i && !m.ack)
                exp_q.push_back(reg_value(m, bus.wb_adr_i));
            m <= model_step(m, pad, bus.wb_cyc_i, bus.wb_stb_i, bus.wb_we_i,
                            bus.wb_adr_i, bus.wb_dat_i);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, want, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: compares outputs with the model and pops read data on ack.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gpio_db", gpio_db, m.db);
            chk("irq", {7'b0, irq}, {7'b0, |m.pend});
            chk("ack", {7'b0, bus.wb_ack_o}, {7'b0, m.ack});
            chk("err_rty", {6'b0, bus.wb_err_o, bus.wb_rty_o}, 8'h00);
            if (bus.wb_ack_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", bus.wb_dat_o, 8'hxx);
                end else begin
                    chk("rdata", bus.wb_dat_o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic bus_access(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                              output logic [7:0] rd);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.wb_ack_o) break;
        end
        rd = bus.wb_dat_o;
        chk("bus_ack", {7'b0, bus.wb_ack_o}, 8'h01);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic measure(input string name, input int bitn, input logic lvl,
                           input int lo, input int hi);
        int lat;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (gpio_db[bitn] == lvl) begin
                lat = n;
                break;
            end
        end
        chk_range(name, lat, lo, hi);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] g;
        int         guard;
        int         a;
        int         r;
        int         idx;

        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 8'h00;
        bus.wb_dat_i = 8'h00;
        bus.wb_cti_i = 3'b000;
        bus.wb_bte_i = 2'b00;

        // Reset with pads high
        pad   = 8'hFF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gpio", gpio_db, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_ack", {7'b0, bus.wb_ack_o}, 8'h00);
        chk("rst_dat", bus.wb_dat_o, 8'h00);
        pad = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_access(1'b0, 8'd4, 8'h00, rd);
        chk("rst_thresh", rd, 8'h04);

        // Debounce with thresh=3
        bus_access(1'b1, 8'd4, 8'd3, rd);
        @(negedge clk);
        pad[0] = 1'b1;
        measure("debounce_lat", 0, 1'b1, 11, 14);
        @(negedge clk);
        pad[1] = 1'b1;
        repeat (3) @(negedge clk);
        pad[1] = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch", {7'b0, gpio_db[1]}, 8'h00);

        // Edges and interrupt
        bus_access(1'b1, 8'd1, 8'h01, rd);
        bus_access(1'b1, 8'd2, 8'h02, rd);
        @(negedge clk);
        pad[0] = 1'b0;
        pad[1] = 1'b1;
        repeat (20) @(negedge clk);
        bus_access(1'b0, 8'd3, 8'h00, rd);
        chk("no_pend", rd, 8'h00);
        @(negedge clk);
        pad[0] = 1'b1;
        pad[1] = 1'b0;
        repeat (20) @(negedge clk);
        bus_access(1'b0, 8'd3, 8'h00, rd);
        chk("pend_03", rd, 8'h03);
        chk("irq_set", {7'b0, irq}, 8'h01);

        // Bypass
        bus_access(1'b1, 8'd4, 8'd0, rd);
        @(negedge clk);
        pad[7] = 1'b1;
        measure("bypass_rise", 7, 1'b1, 3, 3);
        @(negedge clk);
        pad[7] = 1'b0;
        measure("bypass_fall", 7, 1'b0, 3, 3);

        // Clean W1C
        bus_access(1'b1, 8'd3, 8'h03, rd);
        chk("irq_drop", {7'b0, irq}, 8'h00);

        // W1C colliding with a new rise on bit 0
        @(negedge clk);
        pad[0] = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        pad[0] = 1'b1;
        repeat (3) @(negedge clk);
        bus_access(1'b1, 8'd3, 8'h01, rd);
        bus_access(1'b0, 8'd3, 8'h00, rd);
        chk("collision", rd & 8'h01, 8'h01);
        chk("collision_irq", {7'b0, irq}, 8'h01);
        bus_access(1'b1, 8'd3, 8'h03, rd);
        chk("irq_drop2", {7'b0, irq}, 8'h00);

        // Held strobe, back-to-back reads of adr 0..5
        @(negedge clk);
        a            = 0;
        guard        = 0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 8'd0;
        while (a < 6 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (bus.wb_ack_o) begin
                if (a == 5) chk("adr5", bus.wb_dat_o, 8'h00);
                a++;
                bus.wb_adr_i = 8'(a);
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        chk_range("held_stb_cycles", guard, 11, 11);

        // Write to read-only level register
        @(negedge clk);
        g = gpio_db;
        bus_access(1'b1, 8'd0, ~g, rd);
        repeat (3) @(negedge clk);
        chk("adr0_write", gpio_db, g);

        // Asynchronous reset mid-count
        bus_access(1'b1, 8'd4, 8'd0, rd);
        @(negedge clk);
        pad = 8'h81;
        repeat (5) @(negedge clk);
        chk("bypass_81", gpio_db, 8'h81);
        bus_access(1'b1, 8'd4, 8'd3, rd);
        @(negedge clk);
        pad = 8'h7E;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gpio", gpio_db, 8'h00);
        chk("async_rst_irq", {7'b0, irq}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_access(1'b0, 8'd4, 8'h00, rd);
        chk("thresh_after_rst", rd, 8'h04);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 2) begin
                a = int'($urandom_range(0, 6));
                if (a == 4)
                    bus_access(1'($urandom_range(0, 1)), 8'(a), 8'($urandom_range(0, 3)), rd);
                else
                    bus_access(1'($urandom_range(0, 1)), 8'(a), 8'($urandom), rd);
            end else begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) begin
                    idx      = int'($urandom_range(0, 7));
                    pad[idx] = ~pad[idx];
                end
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_debounce.md
# gpio_debounce

Eight-bit input conditioning stage that sits directly upstream of the 8-bit GPIO slave. It synchronises raw pad inputs, debounces each bit with a programmable tick-based filter, and presents clean levels on `gpio_db_o`, which drives the GPIO slave's `gpio_i`. It also detects rising and falling edges on the debounced levels and raises a level interrupt. It exposes its own small Wishbone slave register file on the same bus.

## Interface
Parameters:
- `PRESCALE`, default 100: wb_clk cycles per debounce tick; legal range 1..65535.
- `DEFAULT_THRESH`, default 4: reset value of the threshold register.

Ports:
- `wb_clk`, in, 1: the single clock.
- `wb_rst_n`, in, 1: reset. Asynchronous assert, active-low; release is synchronous to `wb_clk` by system design.
- `wb_adr_i`, in, 8: register address.
- `wb_dat_i`, in, 8: write data.
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i`, in, 1 each: Wishbone classic controls.
- `wb_cti_i`, in, 3, and `wb_bte_i`, in, 2: ignored.
- `wb_dat_o`, out, 8: registered read data.
- `wb_ack_o`, out, 1: single-cycle acknowledge.
- `wb_err_o`, `wb_rty_o`, out, 1 each: tied 0.
- `pad_i`, in, 8: raw asynchronous pad inputs.
- `gpio_db_o`, out, 8: debounced levels, connected to the GPIO slave's `gpio_i`.
- `irq_o`, out, 1: OR of all pending bits.

## Operation
Register map (8-bit):
- adr 0: debounced level, read-only.
- adr 1: rise_en, R/W.
- adr 2: fall_en, R/W.
- adr 3: pending, read; write-1-to-clear.
- adr 4: thresh, R/W.
- Other addresses read 0; writes to them and to adr 0 are ignored but still acked.

Input sync and tick:
- Each `pad_i` bit passes through a 2-flop synchroniser giving `sync[7:0]`.
- The prescaler counts 0..PRESCALE-1 and wraps. `tick` is high for one cycle when the count equals PRESCALE-1.

Per-bit debounce, 8-bit counter `cnt[b]`:
- If `sync[b] == db[b]`: `cnt[b]` is 0 on the next cycle, regardless of tick.
- Else, on a tick: `cnt[b]` increments. If `cnt[b]+1 == thresh`, `db[b]` takes `sync[b]` on that same edge and `cnt[b]` returns to 0.
- `cnt[b]` saturates at 255 and never wraps.
- `thresh == 0` is bypass: `db` follows `sync` every cycle and the counters are held at 0.
- A write to thresh clears all counters on the same edge; `db` is not changed.

Edge and interrupt:
- `db_q` is `db` delayed by one cycle.
- `rise[b] = db[b] & ~db_q[b] & rise_en[b]`; `fall[b] = ~db[b] & db_q[b] & fall_en[b]`.
- pending[b] sets on `rise[b] | fall[b]`. A W1C write on the same cycle as a set leaves the bit set (set wins).
- Changing an enable never sets or clears pending.
- `irq_o = |pending`, driven combinationally from the pending flops.

Bus:
- A write takes effect on the edge where `cyc & stb & we` is sampled high.
- `wb_dat_o` is registered from the address every cycle. It is valid together with `wb_ack_o`.

## Timing
- Reset values: `gpio_db_o`=0, `wb_dat_o`=0, `wb_ack_o`=0, `irq_o`=0; pending, enables, counters, sync flops and prescaler all 0; thresh=DEFAULT_THRESH.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Ack:
  - Rises the cycle after `cyc & stb` is sampled while ack is low.
  - Always falls the following cycle.
  - A held strobe therefore gets ack on alternate cycles, and each ack completes exactly one access.
- Latency with thresh=N≥1 and a stable new pad level: 2 cycles of sync, then N ticks. `gpio_db_o` changes between 2+(N-1)·PRESCALE+1 and 2+N·PRESCALE cycles after the pad edge.
- A pad glitch shorter than one tick period resets the counter and never reaches `gpio_db_o`.
- Bypass latency (thresh=0): `gpio_db_o` changes 3 cycles after the pad edge.
- pending and `irq_o` assert 2 cycles after `db` changes: one cycle for `db_q`, one for the pending flop.
- A W1C clear drops `irq_o` the cycle after the write edge if no other bits are pending.

## Test plan
- **Reset:** drive `wb_rst_n` low with pads=0xFF → all outputs 0; read adr 4 → 0x04. Assert reset mid-count → `gpio_db_o` returns to 0 immediately.
- **Debounce:** PRESCALE=4, thresh=3, `pad_i[0]` 0→1 held → `gpio_db_o[0]` rises within 11..14 cycles. A 3-cycle pulse on `pad_i[1]` → `gpio_db_o[1]` stays 0.
- **Bypass:** write thresh=0, toggle `pad_i[7]` → `gpio_db_o[7]` follows exactly 3 cycles later.
- **Edges and interrupt:** rise_en=0x01, fall_en=0x02, toggle bits 0 and 1 in both directions → pending=0x03 and `irq_o`=1. No pending is set for a fall on bit 0 or a rise on bit 1.
- **W1C collision:** W1C 0x01 on the same cycle a new rise sets bit 0 → bit 0 stays set. A clean W1C 0x03 → pending=0, and `irq_o` drops the next cycle.
- **Bus:** back-to-back reads of adr 0..5 with `stb` held → ack toggles every other cycle. Adr 5 reads 0x00. A write to adr 0 leaves `gpio_db_o` unchanged.
